// File: rtl/conv_layer_scheduler.sv
// Layer sequencer for the shared MAC datapath: walks taps, bank groups, pixels and maps,
// muxes feature banks onto multiplier lanes and aligns sload/enable with the multiplier pipe.
module conv_layer_scheduler #(
  parameter int DATA_WIDTH                = 16,
  parameter int INPUT_NUM_MEM             = 6,
  parameter int IFMAP_PAR                 = 2,
  parameter int NUM_ONE_PIXEL_CYCLE_INTER = 9,
  parameter int OUT_FEATURE_WIDTH_W       = 8,
  parameter int OUT_FEATURE_WIDTH_H       = 8,
  parameter int NUM_ONEMULT               = 2,
  parameter int PIPE_LAT                  = 3,
  localparam int NUM_GROUPS = INPUT_NUM_MEM / IFMAP_PAR,
  localparam int TAP_W = (NUM_ONE_PIXEL_CYCLE_INTER > 1) ? $clog2(NUM_ONE_PIXEL_CYCLE_INTER) : 1,
  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int X_W   = (OUT_FEATURE_WIDTH_W > 1) ? $clog2(OUT_FEATURE_WIDTH_W) : 1,
  localparam int Y_W   = (OUT_FEATURE_WIDTH_H > 1) ? $clog2(OUT_FEATURE_WIDTH_H) : 1,
  localparam int MAP_W = (NUM_ONEMULT > 1) ? $clog2(NUM_ONEMULT) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cfg_start,
  input  logic                            stall,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_all,
  output logic                            busy,
  output logic                            layer_done,
  output logic                            in_feature_rden,
  output logic                            weight_rden,
  output logic [TAP_W-1:0]                tap_idx,
  output logic [GRP_W-1:0]                bank_grp,
  output logic [X_W-1:0]                  out_x,
  output logic [Y_W-1:0]                  out_y,
  output logic [MAP_W-1:0]                out_map,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0] in_feature_q_mux_all,
  output logic                            accum_sload,
  output logic                            enable_mult,
  output logic                            pixel_valid
);

  localparam int LANE_BITS = DATA_WIDTH * IFMAP_PAR;
  localparam int DRAIN_W   = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, next_state;
  logic [DRAIN_W-1:0] drain_cnt;

  logic issue;
  logic tap_last, grp_last, x_last, y_last, map_last;
  logic first_issue, last_pix_issue, last_issue;

  logic [PIPE_LAT-1:0] issue_sr, sload_sr;
  logic [PIPE_LAT:0]   last_pix_sr, final_sr;
  logic [GRP_W-1:0]    grp_d1;
  logic [LANE_BITS-1:0] lane_next;

  assign issue    = (state == RUN) && !stall;
  assign tap_last = (tap_idx == TAP_W'(NUM_ONE_PIXEL_CYCLE_INTER - 1));
  assign grp_last = (bank_grp == GRP_W'(NUM_GROUPS - 1));
  assign x_last   = (out_x == X_W'(OUT_FEATURE_WIDTH_W - 1));
  assign y_last   = (out_y == Y_W'(OUT_FEATURE_WIDTH_H - 1));
  assign map_last = (out_map == MAP_W'(NUM_ONEMULT - 1));

  assign first_issue    = issue && (tap_idx == '0) && (bank_grp == '0);
  assign last_pix_issue = issue && tap_last && grp_last;
  assign last_issue     = last_pix_issue && x_last && y_last && map_last;

  assign in_feature_rden = issue;
  assign weight_rden     = issue;
  assign busy            = (state != IDLE);
  assign enable_mult     = issue_sr[PIPE_LAT-1];
  assign accum_sload     = sload_sr[PIPE_LAT-1];
  assign pixel_valid     = last_pix_sr[PIPE_LAT];
  assign layer_done      = final_sr[PIPE_LAT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
    end
  end

  // DRAIN lasts PIPE_LAT+1 cycles so the final pixel_valid/layer_done lands on its last cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_start) next_state = RUN;
      RUN:     if (last_issue) next_state = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_W'(PIPE_LAT)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tap_idx  <= '0;
      bank_grp <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_map  <= '0;
    end else if (issue) begin
      if (!tap_last) begin
        tap_idx <= tap_idx + TAP_W'(1);
      end else begin
        tap_idx <= '0;
        if (!grp_last) begin
          bank_grp <= bank_grp + GRP_W'(1);
        end else begin
          bank_grp <= '0;
          if (!x_last) begin
            out_x <= out_x + X_W'(1);
          end else begin
            out_x <= '0;
            if (!y_last) begin
              out_y <= out_y + Y_W'(1);
            end else begin
              out_y   <= '0;
              out_map <= map_last ? '0 : out_map + MAP_W'(1);
            end
          end
        end
      end
    end
  end

  // Delay lines free-run through stalls so a stalled cycle travels down the pipe as a bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_sr    <= '0;
      sload_sr    <= '0;
      last_pix_sr <= '0;
      final_sr    <= '0;
      grp_d1      <= '0;
    end else begin
      issue_sr    <= {issue_sr[PIPE_LAT-2:0], issue};
      sload_sr    <= {sload_sr[PIPE_LAT-2:0], first_issue};
      last_pix_sr <= {last_pix_sr[PIPE_LAT-1:0], last_pix_issue};
      final_sr    <= {final_sr[PIPE_LAT-1:0], last_issue};
      grp_d1      <= bank_grp;
    end
  end

  always_comb begin
    lane_next = in_feature_q_all[LANE_BITS-1:0];
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp_d1 == GRP_W'(g)) lane_next = in_feature_q_all[g*LANE_BITS +: LANE_BITS];
    end
  end

  // RAM data belongs to the previous cycle's issue; bubbles leave the lane register untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_feature_q_mux_all <= '0;
    end else if (issue_sr[0]) begin
      in_feature_q_mux_all <= lane_next;
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Self-checking bench for conv_layer_scheduler: directed vector tables plus a randomized
// run compared every cycle against an arithmetic model of the layer schedule.
module tb_conv_layer_scheduler;

  localparam int DW = 16, NM = 6, PAR = 2, NG = 3, INTER = 9;
  localparam int W = 8, H = 8, MAPS = 2, PL = 3;
  localparam int PIX_ISSUES = NG * INTER;
  localparam int TOTAL = W * H * MAPS * PIX_ISSUES;
  localparam int MAXC = 8192;
  localparam int NSIG = 13;
  localparam int S_BUSY = 0, S_RDEN = 1, S_WRDEN = 2, S_SLOAD = 3, S_EN = 4, S_PV = 5,
                 S_DONE = 6, S_TAP = 7, S_GRP = 8, S_X = 9, S_Y = 10, S_MAP = 11, S_QMUX = 12;

  typedef struct {
    int cyc;
    int sig;
    int exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset, cfg_start, stall;
  logic [DW*NM-1:0] in_feature_q_all;
  logic busy, layer_done, in_feature_rden, weight_rden;
  logic [3:0] tap_idx;
  logic [1:0] bank_grp;
  logic [2:0] out_x, out_y;
  logic [0:0] out_map;
  logic [DW*PAR-1:0] in_feature_q_mux_all;
  logic accum_sload, enable_mult, pixel_valid;

  int checks = 0;
  int failures = 0;
  int t;
  int done_cycle, pv_count, done_count;

  bit m_busy;
  int m_n;
  logic [DW*PAR-1:0] m_q;
  bit h_issue[MAXC], h_first[MAXC], h_lastpix[MAXC], h_final[MAXC];
  int h_grp[MAXC];
  logic [DW*NM-1:0] h_data[MAXC];
  int rec[MAXC][NSIG];
  string sig_name[NSIG] = '{"busy", "in_feature_rden", "weight_rden", "accum_sload",
                            "enable_mult", "pixel_valid", "layer_done", "tap_idx",
                            "bank_grp", "out_x", "out_y", "out_map", "q_mux"};
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  conv_layer_scheduler dut (
    .clock                (clock),
    .reset                (reset),
    .cfg_start            (cfg_start),
    .stall                (stall),
    .in_feature_q_all     (in_feature_q_all),
    .busy                 (busy),
    .layer_done           (layer_done),
    .in_feature_rden      (in_feature_rden),
    .weight_rden          (weight_rden),
    .tap_idx              (tap_idx),
    .bank_grp             (bank_grp),
    .out_x                (out_x),
    .out_y                (out_y),
    .out_map              (out_map),
    .in_feature_q_mux_all (in_feature_q_mux_all),
    .accum_sload          (accum_sload),
    .enable_mult          (enable_mult),
    .pixel_valid          (pixel_valid)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs come from the flat issue index m_n and the per-cycle issue history.
  task automatic model_and_check();
    bit run_now, e_issue, e_done;
    int e_tap, e_grp, e_x, e_y, e_map, pos;
    int act[NSIG];
    int exp_v[NSIG];
    run_now = m_busy && (m_n < TOTAL);
    e_issue = run_now && !stall;
    e_tap = 0; e_grp = 0; e_x = 0; e_y = 0; e_map = 0;
    if (run_now) begin
      e_tap = m_n % INTER;
      e_grp = (m_n / INTER) % NG;
      e_x   = (m_n / PIX_ISSUES) % W;
      e_y   = (m_n / (PIX_ISSUES * W)) % H;
      e_map = m_n / (PIX_ISSUES * W * H);
    end
    pos = m_n % PIX_ISSUES;
    h_issue[t]   = e_issue;
    h_first[t]   = e_issue && (pos == 0);
    h_lastpix[t] = e_issue && (pos == PIX_ISSUES - 1);
    h_final[t]   = e_issue && (m_n == TOTAL - 1);
    h_grp[t]     = e_grp;
    h_data[t]    = in_feature_q_all;
    if (t >= 2 && h_issue[t-2]) begin
      for (int j = 0; j < PAR; j++) m_q[j*DW +: DW] = h_data[t-1][(h_grp[t-2]*PAR + j)*DW +: DW];
    end
    e_done = (t > PL) && h_final[t-PL-1];
    exp_v[S_BUSY]  = int'(m_busy);
    exp_v[S_RDEN]  = int'(e_issue);
    exp_v[S_WRDEN] = int'(e_issue);
    exp_v[S_SLOAD] = int'((t >= PL) && h_first[t-PL]);
    exp_v[S_EN]    = int'((t >= PL) && h_issue[t-PL]);
    exp_v[S_PV]    = int'((t > PL) && h_lastpix[t-PL-1]);
    exp_v[S_DONE]  = int'(e_done);
    exp_v[S_TAP]   = e_tap;
    exp_v[S_GRP]   = e_grp;
    exp_v[S_X]     = e_x;
    exp_v[S_Y]     = e_y;
    exp_v[S_MAP]   = e_map;
    exp_v[S_QMUX]  = int'(m_q);
    act[S_BUSY]  = int'(busy);
    act[S_RDEN]  = int'(in_feature_rden);
    act[S_WRDEN] = int'(weight_rden);
    act[S_SLOAD] = int'(accum_sload);
    act[S_EN]    = int'(enable_mult);
    act[S_PV]    = int'(pixel_valid);
    act[S_DONE]  = int'(layer_done);
    act[S_TAP]   = int'(tap_idx);
    act[S_GRP]   = int'(bank_grp);
    act[S_X]     = int'(out_x);
    act[S_Y]     = int'(out_y);
    act[S_MAP]   = int'(out_map);
    act[S_QMUX]  = int'(in_feature_q_mux_all);
    for (int s = 0; s < NSIG; s++) begin
      checkOutput(sig_name[s], t, act[s], exp_v[s]);
      rec[t][s] = act[s];
    end
    if (pixel_valid) pv_count++;
    if (layer_done) done_count++;
    if (e_done) done_cycle = t;
    if (e_issue) m_n++;
    if (e_done) m_busy = 1'b0;
    else if (!m_busy && cfg_start) begin
      m_busy = 1'b1;
      m_n = 0;
    end
  endtask

  task automatic run_cycle();
    @(negedge clock);
    model_and_check();
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cfg_start = 1'b0;
    stall = 1'b0;
    in_feature_q_all = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    t = 0;
    m_busy = 1'b0;
    m_n = 0;
    m_q = '0;
    done_cycle = -1;
    pv_count = 0;
    done_count = 0;
    for (int i = 0; i < MAXC; i++) begin
      h_issue[i] = 0; h_first[i] = 0; h_lastpix[i] = 0; h_final[i] = 0;
    end
  endtask

  // stall_mode: 0 none, 1 cycles 5..7, 2 random; extra_start: extra pulse cycle, -2 random pulses.
  task automatic applyStimulus(input int stall_mode, input int data_mode, input int extra_start,
                               input int stop_at);
    bit fin = 0;
    while (!fin) begin
      if (done_cycle >= 0) cfg_start = 1'b0;
      else if (extra_start == -2) cfg_start = (t == 0) || ($urandom_range(0, 39) == 0);
      else cfg_start = (t == 0) || (t == extra_start);
      case (stall_mode)
        1:       stall = (t >= 5 && t <= 7);
        2:       stall = ($urandom_range(0, 7) == 0);
        default: stall = 1'b0;
      endcase
      if (data_mode == 0) begin
        for (int k = 0; k < NM; k++) in_feature_q_all[k*DW +: DW] = DW'(k + 1);
      end else begin
        for (int k = 0; k < NM; k++) in_feature_q_all[k*DW +: DW] = DW'($urandom);
      end
      run_cycle();
      if (stop_at > 0 && t == stop_at) fin = 1;
      else if (done_cycle >= 0 && t == done_cycle + 2) fin = 1;
      else if (t >= MAXC - 1) begin
        checkOutput("timeout_layer_done", t, 0, 1);
        fin = 1;
      end
    end
  endtask

  initial begin
    tbl_a = '{'{0, S_BUSY, 0}, '{1, S_BUSY, 1}, '{0, S_RDEN, 0}, '{1, S_RDEN, 1},
              '{3456, S_RDEN, 1}, '{3457, S_RDEN, 0}, '{3, S_SLOAD, 0}, '{4, S_SLOAD, 1},
              '{4, S_EN, 1}, '{30, S_PV, 0}, '{31, S_PV, 1}, '{3459, S_DONE, 0},
              '{3460, S_DONE, 1}, '{3460, S_BUSY, 1}, '{3461, S_BUSY, 0},
              '{3, S_QMUX, 32'h0002_0001}, '{12, S_QMUX, 32'h0004_0003}, '{10, S_GRP, 1},
              '{216, S_X, 7}, '{217, S_X, 0}, '{217, S_Y, 1}, '{1728, S_Y, 7},
              '{1729, S_MAP, 1}, '{1729, S_Y, 0}};
    tbl_b = '{'{5, S_TAP, 4}, '{7, S_TAP, 4}, '{8, S_TAP, 4}, '{9, S_TAP, 5},
              '{6, S_RDEN, 0}, '{7, S_EN, 1}, '{8, S_EN, 0}, '{10, S_EN, 0}, '{11, S_EN, 1},
              '{3462, S_DONE, 0}, '{3463, S_DONE, 1}, '{3464, S_BUSY, 0}};

    // Run A: clean layer, constant bank data, stray cfg_start during RUN.
    do_reset();
    applyStimulus(0, 0, 100, 0);
    for (int i = 0; i < tbl_a.size(); i++)
      checkOutput({"tblA_", sig_name[tbl_a[i].sig]}, tbl_a[i].cyc,
                  rec[tbl_a[i].cyc][tbl_a[i].sig], tbl_a[i].exp);
    checkOutput("pixel_valid_count", t, pv_count, W * H * MAPS);
    checkOutput("layer_done_count", t, done_count, 1);

    // Run B: three-cycle stall window.
    do_reset();
    applyStimulus(1, 1, -1, 0);
    for (int i = 0; i < tbl_b.size(); i++)
      checkOutput({"tblB_", sig_name[tbl_b[i].sig]}, tbl_b[i].cyc,
                  rec[tbl_b[i].cyc][tbl_b[i].sig], tbl_b[i].exp);

    // Run C: random stalls, data and cfg_start pulses.
    do_reset();
    applyStimulus(2, 1, -2, 0);
    checkOutput("rand_layer_done_count", t, done_count, 1);
    checkOutput("rand_pixel_valid_count", t, pv_count, W * H * MAPS);

    // Run D: reset mid-layer, then restart from pixel zero.
    do_reset();
    applyStimulus(0, 1, -1, 50);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", t, int'(busy), 0);
    checkOutput("rst_rden", t, int'(in_feature_rden), 0);
    checkOutput("rst_enable_mult", t, int'(enable_mult), 0);
    checkOutput("rst_tap_idx", t, int'(tap_idx), 0);
    checkOutput("rst_out_x", t, int'(out_x), 0);
    checkOutput("rst_q_mux", t, int'(in_feature_q_mux_all), 0);
    checkOutput("rst_layer_done", t, int'(layer_done), 0);
    do_reset();
    applyStimulus(0, 1, -1, 40);
    checkOutput("restart_busy", 1, rec[1][S_BUSY], 1);
    checkOutput("restart_out_x", 1, rec[1][S_X], 0);
    checkOutput("restart_out_y", 1, rec[1][S_Y], 0);
    checkOutput("restart_out_map", 1, rec[1][S_MAP], 0);
    checkOutput("restart_tap_idx", 2, rec[2][S_TAP], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
Sequences one convolution layer over the shared multiply-accumulate datapath. It walks every output pixel of every output map. For each pixel it issues NUM_ONE_PIXEL_CYCLE read cycles across the input-feature bank groups. It time-multiplexes INPUT_NUM_MEM banks onto IFMAP_PAR multiplier lanes and aligns sload/enable with the multiplier pipeline. It sits between the layer-level start/done handshake and the feature/weight RAMs plus multiplier array, and provides the layer-level counter and start/done sequencing for the datapath.

Parameters:
DATA_WIDTH, 16, feature word width
INPUT_NUM_MEM, 6, input-feature banks; must be a multiple of IFMAP_PAR
IFMAP_PAR, 2, multiplier lanes fed per cycle
NUM_GROUPS, INPUT_NUM_MEM/IFMAP_PAR, bank groups (derived localparam)
NUM_ONE_PIXEL_CYCLE_INTER, 9, taps issued per bank group per pixel
OUT_FEATURE_WIDTH_W, 8, output map width
OUT_FEATURE_WIDTH_H, 8, output map height
NUM_ONEMULT, 2, output maps computed sequentially per layer
PIPE_LAT, 3, issue-to-multiplier latency in cycles; must be >= 2

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
cfg_start  in  1  layer start request, sampled in IDLE only
stall  in  1  suppresses issue in RUN
in_feature_q_all  in  DATA_WIDTH*INPUT_NUM_MEM  bank read data, one cycle after rden
busy  out  1  high from first RUN cycle until layer_done
layer_done  out  1  one-cycle pulse at layer completion
in_feature_rden  out  1  feature RAM read enable, issue cycle
weight_rden  out  1  weight RAM read enable, issue cycle
tap_idx  out  clog2(NUM_ONE_PIXEL_CYCLE_INTER)  current tap, for address generators
bank_grp  out  clog2(NUM_GROUPS)  current bank group, issue cycle
out_x / out_y  out  clog2(W) / clog2(H)  current output pixel
out_map  out  clog2(NUM_ONEMULT)  current output map
in_feature_q_mux_all  out  DATA_WIDTH*IFMAP_PAR  registered lane data
accum_sload  out  1  accumulator reload, aligned to multiplier input
enable_mult  out  1  multiplier valid, aligned to multiplier input
pixel_valid  out  1  accumulator result for one pixel complete

Behaviour:
- Reset (reset=0, asynchronous) drives all outputs, counters, delay lines and the lane register to 0 and sets state to IDLE. Reset mid-layer aborts the layer with no layer_done.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN when cfg_start=1.
  - RUN to DRAIN after the last issue cycle.
  - DRAIN to IDLE after PIPE_LAT+1 cycles.
  - cfg_start is ignored outside IDLE.
- Issue cycle: a RUN cycle with stall=0. In it in_feature_rden=weight_rden=1; otherwise both are 0.
- Counter nesting on each issue cycle, all wrapping to 0:
  - tap_idx 0..INTER-1
  - then bank_grp 0..NUM_GROUPS-1
  - then out_x, then out_y, then out_map.
- Last issue cycle: all counters at their maximum. Counters return to 0 in the following cycle.
- Stall freezes every issue counter. Stall is ignored in IDLE and DRAIN.
- Delay lines shift every cycle regardless of stall, so a stall becomes a bubble with enable_mult=0 and accum_sload=0.
- Lane mux: lane j = bank (grp_d1*IFMAP_PAR + j), where grp_d1 is bank_grp delayed one cycle. The mux output is registered, so in_feature_q_mux_all is valid at issue+2. It holds its value during bubbles.
- enable_mult asserts at issue+PIPE_LAT for every issue cycle.
- accum_sload asserts at issue+PIPE_LAT only for the first issue of each pixel (tap_idx=0, bank_grp=0).
- pixel_valid is a one-cycle pulse at issue+PIPE_LAT+1 of each pixel's last issue.
- layer_done coincides with the final pixel_valid. busy drops in the following cycle.
- Total issue cycles = W*H*NUM_ONEMULT*NUM_GROUPS*INTER; with defaults 128*27 = 3456.
- Counter widths are computed with clog2 and are at least 1 bit.

Test Plan:
1. Reset then cfg_start pulse at cycle 0, no stall, defaults -> busy=1 from cycle 1. rden high for cycles 1..3456. First accum_sload at cycle 4. First pixel_valid at cycle 31. pixel_valid count = 128. layer_done at cycle 3460 only. busy=0 at 3461.
2. Bank mux: bank k data = k+1 held constant -> at issue cycle 10 (first grp=1 issue), q_mux at cycle 12 = {4,3}. At cycle 3 it = {2,1}.
3. stall=1 for cycles 5..7 -> tap_idx frozen at 4. enable_mult=0 at cycles 8..10. Every later event is shifted by 3, so layer_done at 3463.
4. cfg_start pulsed at cycle 100 during RUN -> ignored. Exactly one layer_done.
5. reset asserted at cycle 50 -> all outputs 0 immediately. A new cfg_start after release restarts at out_x=out_y=out_map=0.
6. Counter wrap: at the last issue of pixel (7,0,map 0), the next cycle shows out_x=0, out_y=1. After pixel (7,7,map 0), out_map=1 and out_y=0.
